// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: the core writes N, strobes GO, polls STATUS and reads RESULT.
// Computes N! with one multiply per clock; an out-of-range N reports an error without computing.
module fact_accel #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_W    = 4,
  parameter int unsigned N_MAX  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam logic [N_W-1:0] N_MAX_V = N_W'(N_MAX);
  localparam logic [N_W-1:0] CNT_ONE = N_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [N_W-1:0]    n_reg;
  logic [N_W-1:0]    cnt;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              err;
  logic              start_c;

  // Upper write-data bits are never stored.
  logic unused_wd;
  assign unused_wd = ^wd[DATA_W-1:N_W];

  assign start_c = we && (a == ADDR_GO) && wd[0];

  // Operand register, sequencer and datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      n_reg  <= '0;
      cnt    <= '0;
      prod   <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (we && (a == ADDR_N)) begin
        n_reg <= wd[N_W-1:0];
      end
      case (state)
        IDLE, DONE: begin
          if (start_c) begin
            if (n_reg > N_MAX_V) begin
              result <= '0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt   <= n_reg;
              prod  <= DATA_W'(1);
              done  <= 1'b0;
              err   <= 1'b0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // A start during BUSY is ignored; the latched cnt drives the loop.
          if (cnt <= CNT_ONE) begin
            result <= prod;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            prod <= prod * DATA_W'(cnt);
            cnt  <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency read mux, matching data memory's combinational read.
  always_comb begin
    rd = '0;
    case (a)
      ADDR_N:      rd = DATA_W'(n_reg);
      ADDR_GO:     rd = DATA_W'(state == BUSY);
      ADDR_STATUS: rd = DATA_W'({err, done});
      ADDR_RESULT: rd = result;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel: expected results are queued at GO and compared when done rises.
module tb_fact_accel;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_W    = 4;
  localparam int unsigned N_MAX  = 12;
  localparam int          POLL_LIMIT = 64;

  typedef struct {
    int              n;
    logic [31:0]     result;
    logic            err;
    int              lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [1:0]        a;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_result = '0;

  fact_accel #(.DATA_W(DATA_W), .N_W(N_W), .N_MAX(N_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= n; i++) p = p * 32'(i);
    e.n      = n;
    e.err    = (n > int'(N_MAX));
    e.result = e.err ? 32'd0 : p;
    e.lat    = e.err ? 0 : ((n <= 1) ? 1 : n);
    return e;
  endfunction

  // Returns one posedge + 1 after the edge that samples the write.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
  endtask

  task automatic read_all_zero(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check($sformatf("%s_a%0d", tag, i), v, 32'd0);
    end
  endtask

  task automatic start_op(input int n);
    bus_write(2'd0, 32'(n));
    exp_q.push_back(model(n));
    bus_write(2'd1, 32'd1);
  endtask

  // Poll STATUS each edge from start_edges, then pop and compare.
  task automatic finish_op(input int start_edges);
    exp_t        e;
    logic [31:0] st, bz, res;
    logic        saw_busy;
    int          edges;
    e        = exp_q.pop_front();
    edges    = start_edges;
    saw_busy = 1'b0;
    if (start_edges == 0 && !e.err) begin
      bus_read(2'd3, res);
      check($sformatf("hold_n%0d", e.n), res, last_result);
    end
    forever begin
      bus_read(2'd2, st);
      bus_read(2'd1, bz);
      if (bz[0]) saw_busy = 1'b1;
      if (st[0] || edges >= POLL_LIMIT) break;
      @(posedge clk);
      #1;
      edges++;
    end
    check($sformatf("done_n%0d", e.n), 32'(st[0]), 32'd1);
    check($sformatf("lat_n%0d", e.n), 32'(edges), 32'(e.lat));
    check($sformatf("err_n%0d", e.n), 32'(st[1]), 32'(e.err));
    if (start_edges == 0)
      check($sformatf("busy_n%0d", e.n), 32'(saw_busy), 32'(!e.err));
    bus_read(2'd3, res);
    check($sformatf("result_n%0d", e.n), res, e.result);
    last_result = e.result;
  endtask

  task automatic run(input int n);
    start_op(n);
    finish_op(0);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b0;
    we  = 1'b0;
    a   = 2'd0;
    wd  = '0;

    #2;
    read_all_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    read_all_zero("post_rst");

    run(5);
    run(0);
    run(1);
    run(12);
    run(13);
    run(3);

    // Operand write and second GO while busy must not disturb the run.
    start_op(6);
    bus_write(2'd0, 32'd2);
    bus_write(2'd1, 32'd1);
    finish_op(2);
    bus_read(2'd0, v);
    check("n_after_busy_write", v, 32'd2);
    exp_q.push_back(model(2));
    bus_write(2'd1, 32'd1);
    finish_op(0);

    // Asynchronous reset in the middle of a computation.
    bus_write(2'd0, 32'd10);
    bus_write(2'd1, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    read_all_zero("mid_rst");
    last_result = '0;
    @(negedge clk);
    rst = 1'b1;
    run(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
